// File: rtl/alu_pkg.sv
// Operation encodings shared by the 1-bit ALU slice, the 24-bit ALU and the control unit.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;

endpackage

// File: rtl/alu1_full_adder1.sv
// One-bit full adder used by the ALU slice for both the sum and the ripple carry.
module full_adder1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/alu1.sv
// One-bit ALU slice with a registered copy of its outputs for pipelined use.
// Define ALU1_MSB_EN to add the Set and Overflow outputs used by the MSB slice.
module alu1
    import alu_pkg::*;
(
    input  logic       A,
    input  logic       B,
    input  logic       CIN,
    input  logic       BInvert,
    input  logic       Less,
    input  logic       shiftRes,
    input  logic [2:0] Op,
    output logic       Result,
    output logic       CarryOut,
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       Result_q,
    output logic       CarryOut_q
`ifdef ALU1_MSB_EN
    ,
    output logic       Set,
    output logic       Overflow
`endif
);

    logic bm;
    logic sum;

    // BInvert is applied uniformly, so logic ops also see the inverted operand.
    assign bm = B ^ BInvert;

    full_adder1 u_fa (
        .a    (A),
        .b    (bm),
        .cin  (CIN),
        .sum  (sum),
        .cout (CarryOut)
    );

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves Result unassigned (no latch).
        Result = 1'b0;
        case (Op)
            OP_AND:  Result = A & bm;
            OP_OR:   Result = A | bm;
            OP_ADD:  Result = sum;
            OP_SLT:  Result = Less;
            OP_XOR:  Result = A ^ bm;
            OP_SLL:  Result = shiftRes;
            default: Result = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Result_q   <= 1'b0;
            CarryOut_q <= 1'b0;
        end else if (en) begin
            Result_q   <= Result;
            CarryOut_q <= CarryOut;
        end
    end

`ifdef ALU1_MSB_EN
    assign Set      = sum;
    assign Overflow = CIN ^ CarryOut;
`endif

endmodule

// File: tb/tb_alu1.sv
// Directed self-checking bench for the alu1 slice: combinational ops and output registers.
// Also exercises Set/Overflow when ALU1_MSB_EN is defined.
module tb_alu1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       A, B, CIN, BInvert, Less, shiftRes, en;
    logic [2:0] Op;
    logic       Result, CarryOut, Result_q, CarryOut_q;
`ifdef ALU1_MSB_EN
    logic       Set, Overflow;
`endif

    int checks   = 0;
    int failures = 0;

    alu1 dut (
        .A          (A),
        .B          (B),
        .CIN        (CIN),
        .BInvert    (BInvert),
        .Less       (Less),
        .shiftRes   (shiftRes),
        .Op         (Op),
        .Result     (Result),
        .CarryOut   (CarryOut),
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .Result_q   (Result_q),
        .CarryOut_q (CarryOut_q)
`ifdef ALU1_MSB_EN
        ,
        .Set        (Set),
        .Overflow   (Overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic a, input logic b,
                         input logic cin, input logic binv);
        Op = op; A = a; B = b; CIN = cin; BInvert = binv;
        #1;
    endtask

    // Expected tables indexed by {A,B}: bit 0 is (0,0), bit 3 is (1,1).
    logic [3:0] exp_and   = 4'b1000;
    logic [3:0] exp_or    = 4'b1110;
    logic [3:0] exp_add   = 4'b0110;
    logic [3:0] exp_addc  = 4'b1000;
    logic [3:0] exp_sub   = 4'b0110;
    logic [3:0] exp_subc  = 4'b1101;
    logic [3:0] exp_xor   = 4'b0110;
    logic [3:0] shift_pat = 4'b1010;

    initial begin
        rst_n = 1'b0; en = 1'b0; Less = 1'b0; shiftRes = 1'b0;
        drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("reset_result_q", Result_q, 1'b0);
        check("reset_carry_q", CarryOut_q, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            drive(3'b000, i[1], i[0], 1'b0, 1'b0);
            check($sformatf("and_%0d", i), Result, exp_and[i]);
            drive(3'b001, i[1], i[0], 1'b0, 1'b0);
            check($sformatf("or_%0d", i), Result, exp_or[i]);
            drive(3'b010, i[1], i[0], 1'b0, 1'b0);
            check($sformatf("add_%0d", i), Result, exp_add[i]);
            check($sformatf("add_cout_%0d", i), CarryOut, exp_addc[i]);
            drive(3'b010, i[1], i[0], 1'b1, 1'b1);
            check($sformatf("sub_%0d", i), Result, exp_sub[i]);
            check($sformatf("sub_cout_%0d", i), CarryOut, exp_subc[i]);
            drive(3'b101, i[1], i[0], 1'b0, 1'b0);
            check($sformatf("xor_%0d", i), Result, exp_xor[i]);
            shiftRes = shift_pat[i];
            drive(3'b110, i[1], i[0], 1'b0, 1'b0);
            check($sformatf("sll_%0d", i), Result, shift_pat[i]);
            Less = 1'b1;
            drive(3'b011, i[0], i[1], 1'b0, 1'b0);
            check($sformatf("slt1_%0d", i), Result, 1'b1);
            Less = 1'b0;
            drive(3'b011, i[0], i[1], 1'b0, 1'b0);
            check($sformatf("slt0_%0d", i), Result, 1'b0);
        end

        drive(3'b100, 1'b1, 1'b1, 1'b0, 1'b0);
        check("rsv100_result", Result, 1'b0);
        check("rsv100_cout", CarryOut, 1'b1);
        drive(3'b111, 1'b1, 1'b1, 1'b0, 1'b0);
        check("rsv111_result", Result, 1'b0);
        check("rsv111_cout", CarryOut, 1'b1);

`ifdef ALU1_MSB_EN
        drive(3'b010, 1'b1, 1'b1, 1'b0, 1'b0);
        check("msb_set", Set, 1'b0);
        check("msb_overflow", Overflow, 1'b1);
        drive(3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
        check("msb_set2", Set, 1'b1);
        check("msb_overflow2", Overflow, 1'b1);
`endif

        // Load ones into both registers, then reset between edges.
        @(negedge clk);
        en = 1'b1;
        drive(3'b010, 1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("load_ones_result_q", Result_q, 1'b1);
        check("load_ones_carry_q", CarryOut_q, 1'b1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_result_q", Result_q, 1'b0);
        check("async_rst_carry_q", CarryOut_q, 1'b0);
        check("rst_comb_result", Result, 1'b1);
        @(posedge clk); #1;
        check("rst_hold_result_q", Result_q, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(3'b010, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("load_result_q", Result_q, 1'b0);
        check("load_carry_q", CarryOut_q, 1'b1);

        @(negedge clk);
        en = 1'b0;
        drive(3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("hold_result_q", Result_q, 1'b0);
        check("hold_carry_q", CarryOut_q, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
